receptor_medida: RTL and testbench

RECEPTOR_MEDIDA -- requirements
Module: receptor_medida

---
 rtl/receptor_medida_pkg.sv | 32 +++
 rtl/receptor_medida_rx.sv | 127 ++++++++++++
 rtl/receptor_medida.sv | 106 ++++++++++
 tb/tb_receptor_medida.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/receptor_medida_pkg.sv
// Shared constants and types for the 7E1 distance-frame receiver.
// Covers the baud timing defaults, the ASCII codes and the receiver state encoding.
package receptor_medida_pkg;

  localparam int CLK_POR_BIT_PADRAO  = 434;
  localparam int CLK_MEIO_BIT_PADRAO = 217;
  localparam int CNT_W               = 16;

  localparam logic [6:0] ASCII_DIGITO_BASE = 7'h30;
  localparam logic [6:0] ASCII_DIGITO_MAX  = 7'h39;
  localparam logic [6:0] ASCII_TERMINADOR  = 7'h23;

  typedef enum logic [3:0] {
    INICIAL  = 4'd0,
    ESPERA   = 4'd1,
    START    = 4'd2,
    DADOS    = 4'd3,
    PARIDADE = 4'd4,
    STOP     = 4'd5,
    ENTREGA  = 4'd6
  } estado_t;

  // 1 when the 8 bits hold an odd number of ones, i.e. the even-parity check fails.
  function automatic logic paridade_impar(input logic [7:0] bits);
    return ^bits;
  endfunction

  function automatic logic eh_digito(input logic [6:0] c);
    return (c >= ASCII_DIGITO_BASE) && (c <= ASCII_DIGITO_MAX);
  endfunction

endpackage

// File: rtl/receptor_medida_rx.sv
// Serial 7E1 character receiver: 2-flop synchronizer, start detection, bit sampling.
// dado_pronto pulses on the stop-bit sample, together with erro_caractere when that character is bad.
module rx_serial_7E1
  import receptor_medida_pkg::*;
#(
  parameter int CLK_POR_BIT  = CLK_POR_BIT_PADRAO,
  parameter int CLK_MEIO_BIT = CLK_MEIO_BIT_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       serial_i,
  output logic [6:0] dado,
  output logic       dado_pronto,
  output logic       erro_caractere,
  output estado_t    estado_o
);

  localparam logic [CNT_W-1:0] CNT_MEIO = CNT_W'(CLK_MEIO_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLK_POR_BIT - 1);

  logic             sinc1_q, sinc2_q, ant_q;
  estado_t          estado_q, estado_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       nbit_q, nbit_d;
  logic [6:0]       dado_q, dado_d;
  logic             par_q, par_d;
  logic             descida_s, fim_s, amostra_stop_s;

  assign descida_s = ant_q & ~sinc2_q;
  assign fim_s     = (cnt_q == {CNT_W{1'b0}});

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sinc1_q  <= 1'b1;
      sinc2_q  <= 1'b1;
      ant_q    <= 1'b1;
      estado_q <= INICIAL;
      cnt_q    <= {CNT_W{1'b0}};
      nbit_q   <= 3'd0;
      dado_q   <= 7'd0;
      par_q    <= 1'b0;
    end else begin
      sinc1_q  <= serial_i;
      sinc2_q  <= sinc1_q;
      ant_q    <= sinc2_q;
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      nbit_q   <= nbit_d;
      dado_q   <= dado_d;
      par_q    <= par_d;
    end
  end

  // Every sample happens on the edge where the down-counter sits at zero.
  always_comb begin
    estado_d       = estado_q;
    cnt_d          = cnt_q;
    nbit_d         = nbit_q;
    dado_d         = dado_q;
    par_d          = par_q;
    amostra_stop_s = 1'b0;
    case (estado_q)
      INICIAL: estado_d = ESPERA;
      ESPERA: begin
        if (descida_s) begin
          estado_d = START;
          cnt_d    = CNT_MEIO;
        end else begin
          estado_d = ESPERA;
        end
      end
      START: begin
        if (!fim_s) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!sinc2_q) begin
          estado_d = DADOS;
          cnt_d    = CNT_BIT;
          nbit_d   = 3'd0;
        end else begin
          estado_d = ESPERA;
        end
      end
      DADOS: begin
        if (fim_s) begin
          dado_d   = {sinc2_q, dado_q[6:1]};
          cnt_d    = CNT_BIT;
          nbit_d   = nbit_q + 3'd1;
          estado_d = (nbit_q == 3'd6) ? PARIDADE : DADOS;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      PARIDADE: begin
        if (fim_s) begin
          par_d    = sinc2_q;
          cnt_d    = CNT_BIT;
          estado_d = STOP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (fim_s) begin
          amostra_stop_s = 1'b1;
          estado_d       = ENTREGA;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ENTREGA: begin
        if (descida_s) begin
          estado_d = START;
          cnt_d    = CNT_MEIO;
        end else begin
          estado_d = ESPERA;
        end
      end
      default: estado_d = INICIAL;
    endcase
  end

  assign dado           = dado_q;
  assign dado_pronto    = amostra_stop_s;
  assign erro_caractere = amostra_stop_s & (paridade_impar({par_q, dado_q}) | ~sinc2_q);
  assign estado_o       = estado_q;

endmodule

// File: rtl/receptor_medida.sv
// Distance receiver top: assembles "DDD#" frames from 7E1 characters into a BCD measurement.
// Any bad character or out-of-place symbol drops the partial frame and pulses erro.
module receptor_medida
  import receptor_medida_pkg::*;
#(
  parameter int CLK_POR_BIT  = CLK_POR_BIT_PADRAO,
  parameter int CLK_MEIO_BIT = CLK_MEIO_BIT_PADRAO
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        entrada_serial,
  output logic [11:0] medida,
  output logic        pronto,
  output logic        erro,
  output logic [6:0]  db_dado,
  output logic [3:0]  db_estado
);

  logic [6:0] dado_s;
  logic       dado_pronto_s, erro_caractere_s, falha_s;
  estado_t    estado_s;

  logic [1:0]  indice_q, indice_d;
  logic [11:0] digitos_q, digitos_d;
  logic [11:0] medida_q, medida_d;
  logic        pronto_q, pronto_d, erro_q, erro_d;
  logic [6:0]  db_dado_q, db_dado_d;

  rx_serial_7E1 #(
    .CLK_POR_BIT  (CLK_POR_BIT),
    .CLK_MEIO_BIT (CLK_MEIO_BIT)
  ) u_rx (
    .clock          (clock),
    .reset          (reset),
    .serial_i       (entrada_serial),
    .dado           (dado_s),
    .dado_pronto    (dado_pronto_s),
    .erro_caractere (erro_caractere_s),
    .estado_o       (estado_s)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      indice_q  <= 2'd0;
      digitos_q <= 12'h000;
      medida_q  <= 12'h000;
      pronto_q  <= 1'b0;
      erro_q    <= 1'b0;
      db_dado_q <= 7'd0;
    end else begin
      indice_q  <= indice_d;
      digitos_q <= digitos_d;
      medida_q  <= medida_d;
      pronto_q  <= pronto_d;
      erro_q    <= erro_d;
      db_dado_q <= db_dado_d;
    end
  end

  // Digits shift in from the right, so after three of them the hundreds sit in the top nibble.
  always_comb begin
    indice_d  = indice_q;
    digitos_d = digitos_q;
    medida_d  = medida_q;
    pronto_d  = 1'b0;
    erro_d    = 1'b0;
    db_dado_d = db_dado_q;
    falha_s   = 1'b0;
    if (dado_pronto_s) begin
      db_dado_d = dado_s;
      if (erro_caractere_s) begin
        falha_s = 1'b1;
      end else if (indice_q != 2'd3) begin
        if (eh_digito(dado_s)) begin
          digitos_d = {digitos_q[7:0], dado_s[3:0]};
          indice_d  = indice_q + 2'd1;
        end else begin
          falha_s = 1'b1;
        end
      end else if (dado_s == ASCII_TERMINADOR) begin
        medida_d  = digitos_q;
        pronto_d  = 1'b1;
        indice_d  = 2'd0;
        digitos_d = 12'h000;
      end else begin
        falha_s = 1'b1;
      end
    end else begin
      falha_s = 1'b0;
    end
    if (falha_s) begin
      erro_d    = 1'b1;
      indice_d  = 2'd0;
      digitos_d = 12'h000;
    end else begin
      erro_d = 1'b0;
    end
  end

  assign medida    = medida_q;
  assign pronto    = pronto_q;
  assign erro      = erro_q;
  assign db_dado   = db_dado_q;
  assign db_estado = 4'(estado_s);

endmodule

// File: tb/tb_receptor_medida.sv
// Bench for receptor_medida: directed character table, reset/glitch sequences,
// then random frames checked against a frame-level reference model.
module tb_receptor_medida;
  import receptor_medida_pkg::*;

  // Scaled-down baud keeps the run short; the glitch stays well under the sampling offset.
  localparam int BIT    = 40;
  localparam int MEIO   = 20;
  localparam int GLITCH = 9;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        entrada_serial = 1'b1;
  logic [11:0] medida;
  logic        pronto, erro;
  logic [6:0]  db_dado;
  logic [3:0]  db_estado;

  receptor_medida #(.CLK_POR_BIT(BIT), .CLK_MEIO_BIT(MEIO)) dut (
    .clock          (clock),
    .reset          (reset),
    .entrada_serial (entrada_serial),
    .medida         (medida),
    .pronto         (pronto),
    .erro           (erro),
    .db_dado        (db_dado),
    .db_estado      (db_estado)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int pronto_cyc = 0;
  int erro_cyc = 0;

  always @(negedge clock) begin
    if (pronto === 1'b1) pronto_cyc++;
    if (erro === 1'b1) erro_cyc++;
  end

  typedef struct {
    logic [6:0]  ch;
    bit          bad_par;
    bit          bad_stop;
    int          gap;
    int          ev;   // 0 nothing, 1 pronto, 2 erro
    logic [11:0] med;
  } vec_t;

  vec_t       tab[$];
  logic [6:0] model_frame[$];
  logic [11:0] model_med = 12'h000;

  task automatic chk(input string nome, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nome, act, exp);
    end
  endtask

  // Frame-level reference: a frame is the list of accepted characters since the last boundary.
  task automatic model_char(input logic [6:0] c, input bit char_err, output int ev);
    int h, t, u;
    ev = 0;
    if (char_err) begin
      ev = 2;
      model_frame.delete();
    end else begin
      model_frame.push_back(c);
      if (model_frame.size() < 4) begin
        if (c < 7'h30 || c > 7'h39) begin
          ev = 2;
          model_frame.delete();
        end
      end else begin
        if (c == 7'h23) begin
          ev = 1;
          h = int'(model_frame[0]) - 48;
          t = int'(model_frame[1]) - 48;
          u = int'(model_frame[2]) - 48;
          model_med = 12'(h * 256 + t * 16 + u);
        end else begin
          ev = 2;
        end
        model_frame.delete();
      end
    end
  endtask

  task automatic hold(input logic v, input int n);
    entrada_serial = v;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_char(input logic [6:0] c, input bit bad_par, input bit bad_stop, input int gap);
    hold(1'b0, BIT);
    for (int i = 0; i < 7; i++) hold(c[i], BIT);
    hold((^c) ^ bad_par, BIT);
    hold(~bad_stop, BIT);
    if (gap > 0) hold(1'b1, gap);
  endtask

  task automatic char_check(input string tag, input logic [6:0] c, input bit bad_par,
                            input bit bad_stop, input int gap, input int exp_ev,
                            input logic [11:0] exp_med);
    int p0, e0;
    p0 = pronto_cyc;
    e0 = erro_cyc;
    send_char(c, bad_par, bad_stop, gap);
    chk({tag, ".pronto"}, pronto_cyc - p0, (exp_ev == 1) ? 1 : 0);
    chk({tag, ".erro"}, erro_cyc - e0, (exp_ev == 2) ? 1 : 0);
    chk({tag, ".medida"}, int'(medida), int'(exp_med));
    chk({tag, ".db_dado"}, int'(db_dado), int'(c));
  endtask

  task automatic model_check(input string tag, input logic [6:0] c, input bit bad_par,
                             input bit bad_stop, input int gap);
    int ev;
    model_char(c, bad_par | bad_stop, ev);
    char_check(tag, c, bad_par, bad_stop, gap, ev, model_med);
  endtask

  task automatic add(input logic [6:0] c, input bit bp, input bit bs, input int gap,
                     input int ev, input logic [11:0] med);
    vec_t v;
    v.ch = c; v.bad_par = bp; v.bad_stop = bs; v.gap = gap; v.ev = ev; v.med = med;
    tab.push_back(v);
  endtask

  initial begin
    int ev;
    logic [6:0] c;
    bit bp, bs;
    int gap, r;

    // "123#"
    add(7'h31, 0, 0, 0, 0, 12'h000); add(7'h32, 0, 0, 0, 0, 12'h000);
    add(7'h33, 0, 0, 0, 0, 12'h000); add(7'h23, 0, 0, 0, 1, 12'h123);
    // "4", '5' with bad parity, "6#", then "789#"
    add(7'h34, 0, 0, 0, 0, 12'h123); add(7'h35, 1, 0, 0, 2, 12'h123);
    add(7'h36, 0, 0, 0, 0, 12'h123); add(7'h23, 0, 0, 0, 2, 12'h123);
    add(7'h37, 0, 0, 0, 0, 12'h123); add(7'h38, 0, 0, 0, 0, 12'h123);
    add(7'h39, 0, 0, 0, 0, 12'h123); add(7'h23, 0, 0, 0, 1, 12'h789);
    // "12#" then "050#"
    add(7'h31, 0, 0, 0, 0, 12'h789); add(7'h32, 0, 0, 0, 0, 12'h789);
    add(7'h23, 0, 0, 0, 2, 12'h789);
    add(7'h30, 0, 0, 0, 0, 12'h789); add(7'h35, 0, 0, 0, 0, 12'h789);
    add(7'h30, 0, 0, 0, 0, 12'h789); add(7'h23, 0, 0, 0, 1, 12'h050);
    // stop-bit error mid frame, then "666#"
    add(7'h34, 0, 0, 0, 0, 12'h050); add(7'h37, 0, 1, 2 * BIT, 2, 12'h050);
    add(7'h36, 0, 0, 0, 0, 12'h050); add(7'h36, 0, 0, 0, 0, 12'h050);
    add(7'h36, 0, 0, 0, 0, 12'h050); add(7'h23, 0, 0, 0, 1, 12'h666);
    // "111#222#" back to back
    add(7'h31, 0, 0, 0, 0, 12'h666); add(7'h31, 0, 0, 0, 0, 12'h666);
    add(7'h31, 0, 0, 0, 0, 12'h666); add(7'h23, 0, 0, 0, 1, 12'h111);
    add(7'h32, 0, 0, 0, 0, 12'h111); add(7'h32, 0, 0, 0, 0, 12'h111);
    add(7'h32, 0, 0, 0, 0, 12'h111); add(7'h23, 0, 0, 0, 1, 12'h222);
    // digit at position 3, '#' at position 0, ASCII neighbours of the digit range
    add(7'h31, 0, 0, 0, 0, 12'h222); add(7'h32, 0, 0, 0, 0, 12'h222);
    add(7'h33, 0, 0, 0, 0, 12'h222); add(7'h34, 0, 0, 0, 2, 12'h222);
    add(7'h23, 0, 0, 0, 2, 12'h222); add(7'h2F, 0, 0, 0, 2, 12'h222);
    add(7'h3A, 0, 0, 0, 2, 12'h222);
    add(7'h30, 0, 0, 0, 0, 12'h222); add(7'h39, 0, 0, 0, 0, 12'h222);
    add(7'h39, 0, 0, 0, 0, 12'h222); add(7'h23, 0, 0, 0, 1, 12'h099);

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst.medida", int'(medida), 0);
    chk("rst.pronto", int'(pronto), 0);
    chk("rst.erro", int'(erro), 0);
    chk("rst.db_dado", int'(db_dado), 0);
    chk("rst.estado", int'(db_estado), int'(INICIAL));
    reset = 1'b0;
    #1;
    chk("rst.estado_hold", int'(db_estado), int'(INICIAL));
    @(posedge clock);
    #1;
    chk("rst.to_espera", int'(db_estado), int'(ESPERA));
    hold(1'b1, 4);

    for (int i = 0; i < tab.size(); i++) begin
      model_char(tab[i].ch, tab[i].bad_par | tab[i].bad_stop, ev);
      char_check($sformatf("tab%0d", i), tab[i].ch, tab[i].bad_par, tab[i].bad_stop,
                 tab[i].gap, tab[i].ev, tab[i].med);
    end

    // Short low glitch on an idle line must be rejected as a false start
    begin
      int p0, e0;
      p0 = pronto_cyc;
      e0 = erro_cyc;
      hold(1'b0, GLITCH);
      hold(1'b1, 3 * BIT);
      chk("glitch.pronto", pronto_cyc - p0, 0);
      chk("glitch.erro", erro_cyc - e0, 0);
      chk("glitch.estado", int'(db_estado), int'(ESPERA));
      chk("glitch.medida", int'(medida), 12'h099);
    end

    // Reset during the second character of "987#", then "321#"
    model_check("r9", 7'h39, 0, 0, 0);
    hold(1'b0, 3 * BIT);
    reset = 1'b1;
    #1;
    chk("midrst.medida", int'(medida), 0);
    chk("midrst.db_dado", int'(db_dado), 0);
    chk("midrst.estado", int'(db_estado), int'(INICIAL));
    hold(1'b1, 5);
    reset = 1'b0;
    model_frame.delete();
    model_med = 12'h000;
    hold(1'b1, 3);
    model_check("r3", 7'h33, 0, 0, 0);
    model_check("r2", 7'h32, 0, 0, 0);
    model_check("r1", 7'h31, 0, 0, 0);
    model_check("r#", 7'h23, 0, 0, 0);
    chk("midrst.final", int'(medida), 12'h321);

    // Random frames against the reference model
    for (int f = 0; f < 20; f++) begin
      for (int k = 0; k < 4; k++) begin
        r = int'($urandom_range(0, 19));
        if (r == 0) c = 7'($urandom_range(32, 126));
        else if (k == 3 && r != 1) c = 7'h23;
        else c = 7'(7'h30 + $urandom_range(0, 9));
        bp = ($urandom_range(0, 24) == 0);
        bs = ($urandom_range(0, 29) == 0);
        if (bs) gap = 2 * BIT;
        else if ($urandom_range(0, 3) == 0) gap = int'($urandom_range(1, BIT));
        else gap = 0;
        model_check($sformatf("rnd%0d_%0d", f, k), c, bp, bs, gap);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
